// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2, stride-2 max-pool sequencer.
//
// Contents:
//   pool_state_t     controller states
//   max1()           clamps a width to at least one bit
//   calc_next_size() output map edge length N for a stride-2 pool
//   calc_groups()    number of IFM groups (passes) per frame
//   calc_sel_width() width of the group-slot select
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_NEXT = 3'd1,
        READ      = 3'd2,
        DRAIN     = 3'd3,
        NOTIFY    = 3'd4
    } pool_state_t;

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int calc_next_size(input int ifm_size, input int kernel_size);
        return (ifm_size - kernel_size) / 2 + 1;
    endfunction

    function automatic int calc_groups(input int ifm_depth, input int units);
        return (ifm_depth + units - 1) / units;
    endfunction

    function automatic int calc_sel_width(input int groups);
        return max1($clog2(groups));
    endfunction

endpackage

// File: rtl/poolb_scan_counter.sv
// Scan counters for one pooling pass.
//
// Walks col 0..2N-1 (inner) and row-pair 0..N-1 (outer), one position per
// step, and counts the output window index 0..N*N-1. The window index moves
// on after each odd column, so while an odd column is being read it holds
// the index of the window that column completes. Everything wraps to zero
// after the final position.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clear          force all counters to zero
//   step           advance one scan position
//   col            current column (0..2N-1)
//   row_pair       current row pair (0..N-1)
//   idx            output window index of the current position
//   col_last       col is at 2N-1
//   row_last       row_pair is at N-1
module poolb_scan_counter
    import pool_pkg::*;
#(
    parameter int N = 5,
    localparam int COL_W = max1($clog2(2 * N)),
    localparam int ROW_W = max1($clog2(N)),
    localparam int IDX_W = max1($clog2(N * N))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row_pair,
    output logic [IDX_W-1:0] idx,
    output logic             col_last,
    output logic             row_last
);

    assign col_last = (col == COL_W'(2 * N - 1));
    assign row_last = (row_pair == ROW_W'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col      <= '0;
            row_pair <= '0;
            idx      <= '0;
        end else if (clear) begin
            col      <= '0;
            row_pair <= '0;
            idx      <= '0;
        end else if (step) begin
            if (col_last) begin
                col      <= '0;
                row_pair <= row_last ? '0 : row_pair + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            // The last column is odd, so the final window wraps here too.
            if (col[0]) begin
                idx <= (col_last && row_last) ? '0 : idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/poolb_seq_ctrl.sv
// Control sequencer for the 2x2, stride-2 max-pool stage.
//
// Reads the even/odd row pair of the current IFM group from a dual-port
// buffer (port A even row, port B odd row), strobes the pool datapath and
// writes one pooled value per window into the next layer's IFM buffer.
// Handshakes with the previous layer (start in, end out) and the next layer
// (start out, end in), and tracks the IFM group when the frame depth spans
// several passes. All outputs are registered.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   start_from_previous           pulse: a group is ready in the IFM buffer
//   conv_ready                    level: next layer can accept start
//   end_from_next                 pulse: next layer released its buffer
//   end_to_previous               pulse: current group fully read
//   ifm_enable_read_A/B_current   read enables (always equal)
//   ifm_address_read_A/B_current  even/odd row read addresses
//   fifo_enable                   datapath column-register load
//   pool_enable                   datapath max-of-4 compute
//   ifm_enable_write_next         next-buffer write enable
//   ifm_address_write_next        next-buffer write address
//   ifm_sel_next                  group slot being written
//   start_to_next                 pulse: full frame available downstream
module poolb_seq_ctrl
    import pool_pkg::*;
#(
    parameter int IFM_SIZE        = 10,
    parameter int IFM_DEPTH       = 16,
    parameter int KERNAL_SIZE     = 2,
    parameter int NUMBER_OF_UNITS = 16,
    localparam int IFM_SIZE_NEXT         = calc_next_size(IFM_SIZE, KERNAL_SIZE),
    localparam int GROUPS                = calc_groups(IFM_DEPTH, NUMBER_OF_UNITS),
    localparam int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    localparam int ADDRESS_SIZE_NEXT_IFM = max1($clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)),
    localparam int SEL_WIDTH             = calc_sel_width(GROUPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    input  logic                             conv_ready,
    input  logic                             end_from_next,
    output logic                             end_to_previous,
    output logic                             ifm_enable_read_A_current,
    output logic                             ifm_enable_read_B_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_A_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_B_current,
    output logic                             fifo_enable,
    output logic                             pool_enable,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic [SEL_WIDTH-1:0]             ifm_sel_next,
    output logic                             start_to_next
);

    localparam int N     = IFM_SIZE_NEXT;
    localparam int COL_W = max1($clog2(2 * N));
    localparam int ROW_W = max1($clog2(N));

    pool_state_t state;
    pool_state_t state_next;

    logic                             drain_second;
    logic [SEL_WIDTH-1:0]             group;
    logic                             next_free;
    logic                             free_now;
    logic                             last_group;
    logic                             in_read;
    logic                             scan_last;
    logic                             drain_exit;
    logic                             notify_fire;

    logic [COL_W-1:0]                 col;
    logic [ROW_W-1:0]                 row_pair;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] idx;
    logic                             col_last;
    logic                             row_last;

    int                               addr_a_calc;
    int                               addr_b_calc;

    // Stage 1 of the strobe delay line: the read just issued.
    logic                             rd_odd;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] rd_idx;
    // Stage 2: the window being pooled this cycle.
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] pool_idx;

    poolb_scan_counter #(
        .N (N)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_read),
        .step     (in_read),
        .col      (col),
        .row_pair (row_pair),
        .idx      (idx),
        .col_last (col_last),
        .row_last (row_last)
    );

    // An end_from_next arriving this cycle counts as the buffer being free,
    // so a waiting group starts without an extra cycle of latency.
    assign free_now   = next_free || end_from_next;
    assign last_group = (group == SEL_WIDTH'(GROUPS - 1));
    assign in_read    = (state == READ);
    assign scan_last  = col_last && row_last;

    // Next-state logic. Only the first group of a frame needs the next
    // layer's buffer to be free; later groups land in the same frame.
    always_comb begin
        state_next  = state;
        drain_exit  = 1'b0;
        notify_fire = 1'b0;
        case (state)
            IDLE: begin
                if (start_from_previous) begin
                    if (group != '0 || free_now) begin
                        state_next = READ;
                    end else begin
                        state_next = WAIT_NEXT;
                    end
                end
            end
            WAIT_NEXT: begin
                if (free_now) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (scan_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_second) begin
                    drain_exit = 1'b1;
                    state_next = last_group ? NOTIFY : IDLE;
                end
            end
            NOTIFY: begin
                if (conv_ready) begin
                    notify_fire = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, drain phase, group tracking and the next-buffer flag.
    // A start_to_next in the same cycle as end_from_next leaves the flag
    // cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            drain_second <= 1'b0;
            group        <= '0;
            next_free    <= 1'b1;
        end else begin
            state        <= state_next;
            drain_second <= (state == DRAIN) && !drain_second;
            if (drain_exit) begin
                group <= last_group ? '0 : group + SEL_WIDTH'(1);
            end
            if (notify_fire) begin
                next_free <= 1'b0;
            end else if (end_from_next) begin
                next_free <= 1'b1;
            end
        end
    end

    always_comb begin
        addr_a_calc = 2 * int'(row_pair) * IFM_SIZE + int'(col);
        addr_b_calc = addr_a_calc + IFM_SIZE;
    end

    // Registered outputs. The IFM buffer returns data one cycle after the
    // read, so the datapath strobes trail the read by one cycle and the
    // write of a completed window trails its odd-column read by two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifm_enable_read_A_current  <= 1'b0;
            ifm_enable_read_B_current  <= 1'b0;
            ifm_address_read_A_current <= '0;
            ifm_address_read_B_current <= '0;
            rd_odd                     <= 1'b0;
            rd_idx                     <= '0;
            fifo_enable                <= 1'b0;
            pool_enable                <= 1'b0;
            pool_idx                   <= '0;
            ifm_enable_write_next      <= 1'b0;
            ifm_address_write_next     <= '0;
            ifm_sel_next               <= '0;
            end_to_previous            <= 1'b0;
            start_to_next              <= 1'b0;
        end else begin
            ifm_enable_read_A_current <= in_read;
            ifm_enable_read_B_current <= in_read;
            rd_odd                    <= in_read && col[0];
            if (in_read) begin
                ifm_address_read_A_current <= ADDRESS_SIZE_IFM'(addr_a_calc);
                ifm_address_read_B_current <= ADDRESS_SIZE_IFM'(addr_b_calc);
                rd_idx                     <= idx;
            end

            fifo_enable <= ifm_enable_read_A_current;
            pool_enable <= ifm_enable_read_A_current && rd_odd;
            pool_idx    <= rd_idx;

            ifm_enable_write_next <= pool_enable;
            if (pool_enable) begin
                ifm_address_write_next <= pool_idx;
            end

            ifm_sel_next    <= group;
            end_to_previous <= (state == DRAIN) && !drain_second;
            start_to_next   <= notify_fire;
        end
    end

endmodule

// File: tb/tb_poolb_seq_ctrl.sv
// Self-checking bench for poolb_seq_ctrl.
//
// Three instances share clk/reset: default parameters, IFM_DEPTH=32 (two
// groups per frame) and IFM_SIZE=11 (odd edge, N=5). The start/end inputs
// are routed only to the selected instance, and its outputs are muxed onto
// a common set of observation signals.
module tb_poolb_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       conv_ready;
    logic       end_next;
    int         dsel;

    logic [2:0] start_g;
    logic [2:0] end_g;

    logic       rd_a   [3];
    logic       rd_b   [3];
    logic [6:0] addr_a [3];
    logic [6:0] addr_b [3];
    logic       fifo   [3];
    logic       pool   [3];
    logic       wr     [3];
    logic [4:0] waddr  [3];
    logic [0:0] gsel   [3];
    logic       endp   [3];
    logic       stn    [3];

    logic       o_rd_a, o_rd_b, o_fifo, o_pool, o_wr, o_end, o_start;
    logic [6:0] o_addr_a, o_addr_b;
    logic [4:0] o_waddr;
    logic [0:0] o_sel;

    int checks;
    int errors;

    typedef struct {
        logic       start;
        logic       rd;
        int         a;
        int         b;
        logic       fifo;
        logic       pool;
        logic       wr;
        int         waddr;
    } vec_t;

    vec_t table_v [8];

    poolb_seq_ctrl dut (
        .clk (clk), .reset (reset),
        .start_from_previous (start_g[0]), .conv_ready (conv_ready), .end_from_next (end_g[0]),
        .end_to_previous (endp[0]),
        .ifm_enable_read_A_current (rd_a[0]), .ifm_enable_read_B_current (rd_b[0]),
        .ifm_address_read_A_current (addr_a[0]), .ifm_address_read_B_current (addr_b[0]),
        .fifo_enable (fifo[0]), .pool_enable (pool[0]),
        .ifm_enable_write_next (wr[0]), .ifm_address_write_next (waddr[0]),
        .ifm_sel_next (gsel[0]), .start_to_next (stn[0])
    );

    poolb_seq_ctrl #(.IFM_DEPTH (32)) dut32 (
        .clk (clk), .reset (reset),
        .start_from_previous (start_g[1]), .conv_ready (conv_ready), .end_from_next (end_g[1]),
        .end_to_previous (endp[1]),
        .ifm_enable_read_A_current (rd_a[1]), .ifm_enable_read_B_current (rd_b[1]),
        .ifm_address_read_A_current (addr_a[1]), .ifm_address_read_B_current (addr_b[1]),
        .fifo_enable (fifo[1]), .pool_enable (pool[1]),
        .ifm_enable_write_next (wr[1]), .ifm_address_write_next (waddr[1]),
        .ifm_sel_next (gsel[1]), .start_to_next (stn[1])
    );

    poolb_seq_ctrl #(.IFM_SIZE (11)) dut11 (
        .clk (clk), .reset (reset),
        .start_from_previous (start_g[2]), .conv_ready (conv_ready), .end_from_next (end_g[2]),
        .end_to_previous (endp[2]),
        .ifm_enable_read_A_current (rd_a[2]), .ifm_enable_read_B_current (rd_b[2]),
        .ifm_address_read_A_current (addr_a[2]), .ifm_address_read_B_current (addr_b[2]),
        .fifo_enable (fifo[2]), .pool_enable (pool[2]),
        .ifm_enable_write_next (wr[2]), .ifm_address_write_next (waddr[2]),
        .ifm_sel_next (gsel[2]), .start_to_next (stn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the handshake pulses to the instance under test only.
    always_comb begin
        start_g       = '0;
        end_g         = '0;
        start_g[dsel] = start;
        end_g[dsel]   = end_next;
    end

    always_comb begin
        o_rd_a   = rd_a[dsel];
        o_rd_b   = rd_b[dsel];
        o_addr_a = addr_a[dsel];
        o_addr_b = addr_b[dsel];
        o_fifo   = fifo[dsel];
        o_pool   = pool[dsel];
        o_wr     = wr[dsel];
        o_waddr  = waddr[dsel];
        o_sel    = gsel[dsel];
        o_end    = endp[dsel];
        o_start  = stn[dsel];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"},    int'(o_rd_a) + int'(o_rd_b), 0);
        check({tag, "_addr"},  int'(o_addr_a) + int'(o_addr_b), 0);
        check({tag, "_strb"},  int'(o_fifo) + int'(o_pool), 0);
        check({tag, "_wr"},    int'(o_wr) + int'(o_waddr), 0);
        check({tag, "_sel"},   int'(o_sel), 0);
        check({tag, "_pulse"}, int'(o_end) + int'(o_start), 0);
    endtask

    // Watches one whole group. With do_start the group is kicked off here;
    // otherwise the caller has already clocked the transition into READ.
    // Cycle 0 is the sample right after that transition edge.
    task automatic check_group(input int n, input int size, input int grp,
                               input int exp_notify, input bit do_start);
        int rc, wc, cyc, first_rd, last_rd, first_wr, last_wr;
        int end_cyc, end_cnt, st_cnt, st_cyc, bad, budget, col, rp;
        rc = 0; wc = 0; cyc = 0; first_rd = -1; last_rd = -1;
        first_wr = -1; last_wr = -1; end_cyc = -1; end_cnt = 0;
        st_cnt = 0; st_cyc = -1; bad = 0;
        budget = 2 * n * n + 20;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        while (cyc < budget && (end_cyc < 0 || cyc < end_cyc + 3)) begin
            step();
            cyc++;
            if (o_rd_a != o_rd_b) bad++;
            if (o_rd_a) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                col = rc % (2 * n);
                rp  = rc / (2 * n);
                check("rd_addr_a", int'(o_addr_a), 2 * rp * size + col);
                check("rd_addr_b", int'(o_addr_b), (2 * rp + 1) * size + col);
                if (int'(o_addr_a) % size >= 2 * n) bad++;
                if (int'(o_addr_b) / size >= 2 * n) bad++;
                rc++;
            end
            if (o_wr) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                check("wr_addr", int'(o_waddr), wc);
                check("wr_sel", int'(o_sel), grp);
                wc++;
            end
            if (o_end) begin
                end_cnt++;
                end_cyc = cyc;
            end
            if (o_start) begin
                st_cnt++;
                st_cyc = cyc;
            end
        end
        check("grp_end_count", end_cnt, 1);
        check("grp_reads", rc, 2 * n * n);
        check("grp_writes", wc, n * n);
        check("grp_first_read", first_rd, 1);
        check("grp_first_write", first_wr, first_rd + 3);
        check("grp_end_timing", end_cyc, last_rd + 1);
        check("grp_last_write", last_wr, last_rd + 2);
        check("grp_bad_addr", bad, 0);
        check("grp_start_to_next", st_cnt, exp_notify);
        if (exp_notify == 1) check("grp_start_timing", st_cyc, last_wr + 1);
    endtask

    task automatic apply_vector(input int i);
        start = table_v[i].start;
        step();
        start = 1'b0;
        check($sformatf("vec%0d_rd", i), int'(o_rd_a), int'(table_v[i].rd));
        check($sformatf("vec%0d_rdb", i), int'(o_rd_b), int'(table_v[i].rd));
        if (table_v[i].rd) begin
            check($sformatf("vec%0d_a", i), int'(o_addr_a), table_v[i].a);
            check($sformatf("vec%0d_b", i), int'(o_addr_b), table_v[i].b);
        end
        check($sformatf("vec%0d_fifo", i), int'(o_fifo), int'(table_v[i].fifo));
        check($sformatf("vec%0d_pool", i), int'(o_pool), int'(table_v[i].pool));
        check($sformatf("vec%0d_wr", i), int'(o_wr), int'(table_v[i].wr));
        if (table_v[i].wr) check($sformatf("vec%0d_waddr", i), int'(o_waddr), table_v[i].waddr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        int guard;
        checks = 0;
        errors = 0;

        // First cycles of a default frame; row 5 also pulses a start that
        // must be ignored while reading.
        //            start rd  a  b   fifo pool wr waddr
        table_v[0] = '{1'b1, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0, 0};
        table_v[1] = '{1'b0, 1'b1, 0, 10, 1'b0, 1'b0, 1'b0, 0};
        table_v[2] = '{1'b0, 1'b1, 1, 11, 1'b1, 1'b0, 1'b0, 0};
        table_v[3] = '{1'b0, 1'b1, 2, 12, 1'b1, 1'b1, 1'b0, 0};
        table_v[4] = '{1'b0, 1'b1, 3, 13, 1'b1, 1'b0, 1'b1, 0};
        table_v[5] = '{1'b1, 1'b1, 4, 14, 1'b1, 1'b1, 1'b0, 0};
        table_v[6] = '{1'b0, 1'b1, 5, 15, 1'b1, 1'b0, 1'b1, 1};
        table_v[7] = '{1'b0, 1'b1, 6, 16, 1'b1, 1'b1, 1'b0, 1};

        dsel       = 0;
        start      = 1'b0;
        conv_ready = 1'b1;
        end_next   = 1'b0;
        reset      = 1'b0;
        step();
        step();
        check_zero("reset");
        reset = 1'b1;
        step();
        check_zero("post_reset");

        for (int i = 0; i < 8; i++) apply_vector(i);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        reset = 1'b0;
        #1;
        check_zero("table_reset");
        step();
        reset = 1'b1;
        step();
        check_zero("table_reset_release");

        $display("[TB] full default frame");
        check_group(5, 10, 0, 1, 1'b1);

        $display("[TB] conv_ready held low");
        end_next = 1'b1;
        step();
        end_next   = 1'b0;
        conv_ready = 1'b0;
        check_group(5, 10, 0, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_start) seen++;
        end
        check("notify_hold", seen, 0);
        conv_ready = 1'b1;
        step();
        check("notify_fire", int'(o_start), 1);
        step();
        check("notify_single", int'(o_start), 0);

        $display("[TB] wait for next layer");
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_rd_a || o_rd_b) seen++;
        end
        check("wait_next_no_reads", seen, 0);
        end_next = 1'b1;
        step();
        end_next = 1'b0;
        check_group(5, 10, 0, 1, 1'b0);

        $display("[TB] two groups per frame");
        dsel = 1;
        step();
        check_group(5, 10, 0, 0, 1'b1);
        check("grp1_sel_before", int'(o_sel), 1);
        check_group(5, 10, 1, 1, 1'b1);

        $display("[TB] odd edge IFM_SIZE=11");
        dsel = 2;
        step();
        check_group(5, 11, 0, 1, 1'b1);

        $display("[TB] reset at read 20");
        dsel = 0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        seen  = 0;
        guard = 0;
        while (seen < 20 && guard < 60) begin
            step();
            guard++;
            if (o_rd_a) seen++;
        end
        check("rst20_reached", seen, 20);
        reset = 1'b0;
        #1;
        check_zero("rst20_now");
        step();
        check_zero("rst20_held");
        reset = 1'b1;
        step();
        check_zero("rst20_release");
        step();
        check_zero("rst20_quiet");
        check_group(5, 10, 0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poolb_seq_ctrl.md
# poolb_seq_ctrl

Control sequencer for the 2×2, stride-2 max-pool stage with NUMBER_OF_UNITS parallel lanes. It sits between the previous conv layer's dual-port IFM buffer and the pool datapath. It generates paired row read addresses (port A: even row, port B: odd row), the datapath `fifo_enable`/`pool_enable` strobes, and write address/enable into the next layer's IFM buffer. It also runs the start/end handshakes with both neighbouring layers and tracks IFM groups when IFM_DEPTH exceeds NUMBER_OF_UNITS.

## Interface
- IFM_SIZE, 10: input map edge length
- IFM_DEPTH, 16: input maps per frame
- KERNAL_SIZE, 2: pool window (fixed stride 2)
- NUMBER_OF_UNITS, 16: parallel pool lanes
- IFM_SIZE_NEXT, (IFM_SIZE-KERNAL_SIZE)/2+1: output edge length N
- GROUPS, ceil(IFM_DEPTH/NUMBER_OF_UNITS): passes per frame
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE)
- ADDRESS_SIZE_NEXT_IFM, $clog2(N*N)
- SEL_WIDTH, max(1,$clog2(GROUPS))
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- start_from_previous  in  1  one-cycle pulse: a group is ready in the IFM buffer
- conv_ready  in  1  level: next conv layer can accept start
- end_from_next  in  1  pulse: next layer has released its IFM buffer
- end_to_previous  out  1  pulse: current group fully read, buffer free
- ifm_enable_read_A_current / _B_current  out  1 each  read enables (always equal)
- ifm_address_read_A_current / _B_current  out  ADDRESS_SIZE_IFM each  read addresses
- fifo_enable  out  1  datapath column-register load
- pool_enable  out  1  datapath max-of-4 compute
- ifm_enable_write_next  out  1  next-buffer write enable
- ifm_address_write_next  out  ADDRESS_SIZE_NEXT_IFM  next-buffer write address
- ifm_sel_next  out  SEL_WIDTH  group slot currently being written
- start_to_next  out  1  pulse: full frame available to next layer

## Operation
- States: IDLE, WAIT_NEXT, READ, DRAIN, NOTIFY.
- `next_free` flag:
  - Set at reset and on `end_from_next`.
  - Cleared on `start_to_next`.
  - If both occur in the same cycle, clear wins.
- IDLE:
  - On `start_from_previous`: go to READ if group≠0 or `next_free`; otherwise go to WAIT_NEXT.
- WAIT_NEXT: go to READ when `next_free`=1.
- READ issues one read per cycle:
  - Counters: col 0..2N-1 (inner), row-pair r 0..N-1 (outer).
  - Port A address = (2r)·IFM_SIZE+col. Port B address = (2r+1)·IFM_SIZE+col.
  - Columns and rows at or beyond 2N are never read (odd IFM_SIZE is truncated).
  - After the read at col=2N-1, r=N-1, go to DRAIN.
- DRAIN lasts 2 cycles:
  - `end_to_previous` pulses in the first DRAIN cycle.
  - Exit: if group=GROUPS-1, go to NOTIFY and wrap group to 0; else increment group and go to IDLE.
- NOTIFY: pulse `start_to_next` in the first cycle with `conv_ready`=1, then go to IDLE.
- Output write address: index k = r·N + col/2, incrementing 0..N²-1 per group.
- `ifm_sel_next` holds the group index for the entire group, including its writes.
- `start_from_previous` outside IDLE is ignored, not queued.
- `end_from_next` is accepted in any state.

## Timing
- Read latency of the IFM buffer is 1 cycle.
- For a read issued at cycle t (with column parity p):
  - `fifo_enable`=1 at t+1.
  - `pool_enable`=1 at t+1 only if p odd.
  - `ifm_enable_write_next`=1 at t+2 only if p odd, with the address of that window.
- First read happens in the cycle after entering READ. First write follows 3 cycles later.
- A group takes 2N² read cycles: 50 for defaults. Its last write is 2 cycles after its last read.
- Reset values:
  - All outputs 0; state IDLE.
  - Counters and group 0; `next_free`=1.
- Reset mid-frame returns immediately to IDLE. No pulses or writes occur after reset is asserted.
- All outputs are registered. Pulses are exactly one cycle wide.

## Structure
- Package `pool_pkg`: state enum, N/GROUPS/SEL_WIDTH localparam functions, max(1,…) helper.
- Sub-module `poolb_scan_counter`:
  - Contains the col/row-pair/output-index counters with wrap flags.
  - Controller FSM, handshake flags and the 2-stage strobe delay line stay in the top.

## Test plan
- Reset then single `start_from_previous` (defaults):
  - 50 reads; A addresses 0..9, 20..29, 40..49…; B addresses 10..19, 30..39…
  - 25 writes at addresses 0..24.
  - `end_to_previous` one cycle after the last read.
  - `start_to_next` after the last write, with `conv_ready`=1.
- `conv_ready`=0 for 10 cycles after DRAIN: controller holds in NOTIFY, `start_to_next` fires in the cycle `conv_ready` rises, exactly one pulse.
- Second start with no `end_from_next`: held in WAIT_NEXT with no reads. `end_from_next` pulse → reads begin the next cycle.
- IFM_DEPTH=32: two starts, `ifm_sel_next`=0 then 1. `start_to_next` only after group 1; no `next_free` wait before group 1.
- IFM_SIZE=11: N=5; column 10 and row 10 are never addressed; 25 writes.
- Reset asserted at read 20, then start again: outputs are 0 immediately, and a fresh frame restarts at address 0.
